lsu_stream_ctrl: RTL and testbench
==================================

// Module: lsu_stream_ctrl
// PURPOSE
//  Parametrised load/store unit for the CGRA array. Holds a per-cycle config program that selects one of NUM_PE
//  PE outputs, issues bank read/write requests with strided address generation, and returns loaded data to the PEs.
//  The program loops modulo its programmed length.
//  Sits between the PE row and the CBG/memory-bank bus. Successor to the fixed 4-PE/unit-stride LSU.
// PARAMETERS
//  DATA_W     32  datapath width
//  ADDR_W     10  bank address width (matches A_W)
//  NUM_PE     4   PE inputs, >=2; PE_SEL_W=$clog2(NUM_PE)
//  CFG_DEPTH  32  config program entries, power of 2; PTR_W=$clog2(CFG_DEPTH)
//  STRIDE_W   4   per-entry unsigned address stride width
// PORTS
//  clk        in  1                 clock
//  rst        in  1                 asynchronous active-low reset
//  cfg_start  in  1                 pulse: clear program, load bases
//  rd_base    in  ADDR_W            read base, sampled on cfg_start
//  wr_base    in  ADDR_W            write base, sampled on cfg_start
//  cfg_valid  in  1                 append cfg_word to program
//  cfg_word   in  CFG_W             {ren,wen,bank[1:0],pe_sel,store_sel,stride}; CFG_W=5+PE_SEL_W+STRIDE_W
//  run        in  1                 advance program one entry per cycle while high
//  pe_data    in  NUM_PE*DATA_W     flattened PE outputs, PE0 at LSBs
//  rd_valid   in  1                 read data return valid
//  rd_data    in  DATA_W            read data return
//  lsu_to_pe  out DATA_W            load register
//  rd_req     out 1                 read request
//  rd_bank    out 2                 read bank select
//  rd_addr    out ADDR_W            read address
//  wr_req     out 1                 write request
//  wr_bank    out 2                 write bank select
//  wr_addr    out ADDR_W            write address
//  wr_data    out DATA_W            store register
//  pc         out PTR_W             current program entry
//  cfg_ovf    out 1                 sticky: cfg_valid received when program full
//  rd_cnt     out 16                reads issued (see CONFIGURATION)
//  wr_cnt     out 16                writes issued (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst=0): all req outputs 0; addrs, pc, cfg_len, bases, cfg_ovf, counters 0;
//   lsu_to_pe and wr_data = all-ones. Config RAM need not be cleared.
//  Priority per cycle: cfg_start > cfg_valid > run.
//   Lower-priority inputs are ignored that cycle; all reqs 0 and pc holds.
//  cfg_start: cfg_len<=0, pc<=0, cfg_ovf<=0; rd_addr<=rd_base, wr_addr<=wr_base.
//  cfg_valid: entry[cfg_len]<=cfg_word, cfg_len++. At cfg_len==CFG_DEPTH: word dropped, cfg_ovf<=1.
//   cfg_len width is PTR_W+1.
//  run=1 and cfg_len>0: entry E=entry[pc] is decoded.
//   Outputs are registered, so they appear the cycle after E is selected:
//   rd_req<=E.ren, rd_bank<=E.bank, wr_req<=E.wen, wr_bank<=E.bank.
//   pc<=(pc==cfg_len-1)?0:pc+1.
//  run=0 or cfg_len==0: rd_req/wr_req<=0; pc, addrs and data regs hold.
//  Address gen: after each cycle with rd_req=1, rd_addr+=stride of the issuing entry. wr_addr likewise with wr_req.
//   Stride is zero-extended; wrap is modulo 2^ADDR_W.
//   The stride is pipelined alongside the req, so the address on the bus equals the address used by that req.
//  Load: lsu_to_pe<=rd_data when rd_valid=1, otherwise holds. Response latency from memory is arbitrary.
//  Store: wr_data is registered with the req: store_sel ? lsu_to_pe : pe_data[pe_sel].
//   pe_sel>=NUM_PE selects PE0.
//  Simultaneous rd_valid with cfg_start: load still captured.
//  Reset mid-run aborts immediately; no partial write is emitted after rst falls.
// CONFIGURATION
//  `LSU_PERF_CNT_EN defined: rd_cnt/wr_cnt count issued rd_req/wr_req cycles.
//   Counters saturate at 16'hFFFF and clear on cfg_start or reset.
//  Not defined: rd_cnt/wr_cnt tied to 0 and no counter flops.
// STRUCTURE
//  Shared package/defines: CFG field offsets, CFG_W computation, bank-select encoding, DATA_W/ADDR_W defaults.
//  Sub-module lsu_addr_gen (base load, strided increment, wrap) instantiated twice, for read and for write.
// TESTING
//  1. Reset, then cfg_start with rd_base=0x010 and 3 entries {ren,stride=2}; run 6 cycles
//     -> rd_addr 0x010,0x012,...,0x01A; pc 0,1,2,0,1,2.
//  2. Write entry pe_sel=2, store_sel=0, pe_data[2]=0xDEADBEEF, wr_base=0x3FF, stride=1; run 2
//     -> wr_data=0xDEADBEEF; wr_addr 0x3FF then 0x000 (wrap).
//  3. Write CFG_DEPTH+1 words -> cfg_len=32, cfg_ovf=1, 33rd word absent from loop.
//  4. rd_valid pulse with rd_data=0x1234, then store_sel=1 write entry -> lsu_to_pe holds 0x1234, wr_data=0x1234.
//  5. cfg_valid and run high together; run with cfg_len=0; run deasserted mid-loop
//     -> no reqs issued, pc holds, resumes at the same entry.
//  6. `LSU_PERF_CNT_EN on: 5 reads, 3 writes -> rd_cnt=5, wr_cnt=3; cfg_start clears both.
//     Macro off: both read 0.

Source files
------------

// File: rtl/lsu_stream_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_stream_ctrl_pkg : config-word layout and defaults for the LSU    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_stream_ctrl_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;

  // Fixed flag/field bits in a config word: ren, wen, bank[1:0], store_sel.
  localparam int CFG_FIXED_W = 5;

  typedef enum logic [1:0] {
    BANK0 = 2'd0,
    BANK1 = 2'd1,
    BANK2 = 2'd2,
    BANK3 = 2'd3
  } bank_e;

  // Word layout, LSB first: stride | store_sel | pe_sel | bank | wen | ren
  function automatic int cfg_width(input int pe_sel_w, input int stride_w);
    return CFG_FIXED_W + pe_sel_w + stride_w;
  endfunction

  function automatic int cfg_off_store(input int stride_w);
    return stride_w;
  endfunction

  function automatic int cfg_off_pe_sel(input int stride_w);
    return stride_w + 1;
  endfunction

  function automatic int cfg_off_bank(input int pe_sel_w, input int stride_w);
    return stride_w + 1 + pe_sel_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_stream_ctrl_addr_gen.sv
// +----------------------------------------------------------------------+
// | lsu_addr_gen : base load plus strided, wrapping bank address counter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_addr_gen #(
  parameter int ADDR_W   = 10,
  parameter int STRIDE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [ADDR_W-1:0]   base,
  input  logic                step,
  input  logic [STRIDE_W-1:0] stride,
  output logic [ADDR_W-1:0]   addr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (step) begin
      addr <= addr + ADDR_W'(stride);
    end
  end

endmodule

`default_nettype wire

// File: rtl/lsu_stream_ctrl.sv
// +----------------------------------------------------------------------+
// | lsu_stream_ctrl : looping config-program LSU with strided addressing |
// | Optional LSU_PERF_CNT_EN enables rd_cnt/wr_cnt.   Rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_stream_ctrl
  import lsu_stream_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_PE    = 4,
  parameter int CFG_DEPTH = 32,
  parameter int STRIDE_W  = 4,
  localparam int PE_SEL_W = $clog2(NUM_PE),
  localparam int PTR_W    = $clog2(CFG_DEPTH),
  localparam int CFG_W    = cfg_width(PE_SEL_W, STRIDE_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [ADDR_W-1:0]        rd_base,
  input  logic [ADDR_W-1:0]        wr_base,
  input  logic                     cfg_valid,
  input  logic [CFG_W-1:0]         cfg_word,
  input  logic                     run,
  input  logic [NUM_PE*DATA_W-1:0] pe_data,
  input  logic                     rd_valid,
  input  logic [DATA_W-1:0]        rd_data,
  output logic [DATA_W-1:0]        lsu_to_pe,
  output logic                     rd_req,
  output logic [1:0]               rd_bank,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     wr_req,
  output logic [1:0]               wr_bank,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [PTR_W-1:0]         pc,
  output logic                     cfg_ovf,
  output logic [15:0]              rd_cnt,
  output logic [15:0]              wr_cnt
);

  localparam int C_OFF_STORE = cfg_off_store(STRIDE_W);
  localparam int C_OFF_PE    = cfg_off_pe_sel(STRIDE_W);
  localparam int C_OFF_BANK  = cfg_off_bank(PE_SEL_W, STRIDE_W);
  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(CFG_DEPTH);

  logic [CFG_W-1:0]    cfg_mem [CFG_DEPTH];
  logic [PTR_W:0]      r_cfg_len;
  logic [STRIDE_W-1:0] r_rd_stride;
  logic [STRIDE_W-1:0] r_wr_stride;

  logic [CFG_W-1:0]    w_entry;
  logic [STRIDE_W-1:0] w_stride;
  logic                w_store_sel;
  logic [PE_SEL_W-1:0] w_pe_sel;
  bank_e               w_bank;
  logic                w_wen;
  logic                w_ren;
  logic                w_issue;
  logic                w_cfg_wr;
  logic                w_pc_last;
  logic [DATA_W-1:0]   w_pe_word;
  logic [DATA_W-1:0]   w_store;

  assign w_entry     = cfg_mem[pc];
  assign w_stride    = w_entry[STRIDE_W-1:0];
  assign w_store_sel = w_entry[C_OFF_STORE];
  assign w_pe_sel    = w_entry[C_OFF_PE +: PE_SEL_W];
  assign w_bank      = bank_e'(w_entry[C_OFF_BANK +: 2]);
  assign w_wen       = w_entry[CFG_W-2];
  assign w_ren       = w_entry[CFG_W-1];

  assign w_cfg_wr  = !cfg_start && cfg_valid && (r_cfg_len != C_FULL);
  assign w_issue   = !cfg_start && !cfg_valid && run && (r_cfg_len != '0);
  assign w_pc_last = ({1'b0, pc} == (r_cfg_len - 1'b1));

  // Out-of-range selects fall through to PE0.
  always_comb begin
    w_pe_word = pe_data[DATA_W-1:0];
    for (int i = 1; i < NUM_PE; i++) begin
      if (w_pe_sel == PE_SEL_W'(i)) begin
        w_pe_word = pe_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_store = w_store_sel ? lsu_to_pe : w_pe_word;

  always_ff @(posedge clk) begin
    if (w_cfg_wr) begin
      cfg_mem[r_cfg_len[PTR_W-1:0]] <= cfg_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_req      <= 1'b0;
      wr_req      <= 1'b0;
      rd_bank     <= 2'd0;
      wr_bank     <= 2'd0;
      pc          <= '0;
      r_cfg_len   <= '0;
      cfg_ovf     <= 1'b0;
      r_rd_stride <= '0;
      r_wr_stride <= '0;
      wr_data     <= '1;
    end else begin
      rd_req <= 1'b0;
      wr_req <= 1'b0;
      if (cfg_start) begin
        r_cfg_len <= '0;
        pc        <= '0;
        cfg_ovf   <= 1'b0;
      end else if (cfg_valid) begin
        if (r_cfg_len == C_FULL) begin
          cfg_ovf <= 1'b1;
        end else begin
          r_cfg_len <= r_cfg_len + 1'b1;
        end
      end else if (w_issue) begin
        rd_req      <= w_ren;
        wr_req      <= w_wen;
        rd_bank     <= w_bank;
        wr_bank     <= w_bank;
        r_rd_stride <= w_stride;
        r_wr_stride <= w_stride;
        if (w_wen) begin
          wr_data <= w_store;
        end
        pc <= w_pc_last ? '0 : pc + 1'b1;
      end
    end
  end

  // Load capture is independent of the config/run priority chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsu_to_pe <= '1;
    end else if (rd_valid) begin
      lsu_to_pe <= rd_data;
    end
  end

  // Stride travels with the registered req, so the bus address is the one used.
  lsu_addr_gen #(.ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) u_rd_addr (
    .clk    (clk),
    .rst    (rst),
    .load   (cfg_start),
    .base   (rd_base),
    .step   (rd_req),
    .stride (r_rd_stride),
    .addr   (rd_addr)
  );

  lsu_addr_gen #(.ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) u_wr_addr (
    .clk    (clk),
    .rst    (rst),
    .load   (cfg_start),
    .base   (wr_base),
    .step   (wr_req),
    .stride (r_wr_stride),
    .addr   (wr_addr)
  );

`ifdef LSU_PERF_CNT_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_cnt <= 16'd0;
      r_wr_cnt <= 16'd0;
    end else if (cfg_start) begin
      r_rd_cnt <= 16'd0;
      r_wr_cnt <= 16'd0;
    end else if (w_issue) begin
      if (w_ren && (r_rd_cnt != 16'hFFFF)) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (w_wen && (r_wr_cnt != 16'hFFFF)) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
    end
  end

  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;
`else
  assign rd_cnt = 16'd0;
  assign wr_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_stream_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_lsu_stream_ctrl : directed self-checking bench for lsu_stream_ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lsu_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start;
  logic [9:0]   rd_base;
  logic [9:0]   wr_base;
  logic         cfg_valid;
  logic [10:0]  cfg_word;
  logic         run;
  logic [127:0] pe_data;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic [31:0]  lsu_to_pe;
  logic         rd_req;
  logic [1:0]   rd_bank;
  logic [9:0]   rd_addr;
  logic         wr_req;
  logic [1:0]   wr_bank;
  logic [9:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [4:0]   pc;
  logic         cfg_ovf;
  logic [15:0]  rd_cnt;
  logic [15:0]  wr_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_stream_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .rd_base   (rd_base),
    .wr_base   (wr_base),
    .cfg_valid (cfg_valid),
    .cfg_word  (cfg_word),
    .run       (run),
    .pe_data   (pe_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .lsu_to_pe (lsu_to_pe),
    .rd_req    (rd_req),
    .rd_bank   (rd_bank),
    .rd_addr   (rd_addr),
    .wr_req    (wr_req),
    .wr_bank   (wr_bank),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pc        (pc),
    .cfg_ovf   (cfg_ovf),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
  );

  function automatic logic [10:0] mk(input logic ren, input logic wen, input logic [1:0] bank,
                                     input logic [1:0] pe, input logic st, input logic [3:0] stride);
    return {ren, wen, bank, pe, st, stride};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [9:0] rb, input logic [9:0] wb);
    cfg_start = 1'b1;
    rd_base   = rb;
    wr_base   = wb;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic load(input logic [10:0] w);
    cfg_valid = 1'b1;
    cfg_word  = w;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfg_start = 1'b0; rd_base = '0; wr_base = '0; cfg_valid = 1'b0;
    cfg_word = '0; run = 1'b0; pe_data = '0; rd_valid = 1'b0; rd_data = '0;
    repeat (2) tick();

    chk("rst_lsu_to_pe", lsu_to_pe, 32'hFFFF_FFFF);
    chk("rst_wr_data", wr_data, 32'hFFFF_FFFF);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_cfg_ovf", cfg_ovf, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    rst = 1'b1;
    tick();

    // 1: read stream, stride 2, 3-entry loop
    start(10'h010, 10'h000);
    chk("t1_base", rd_addr, 10'h010);
    repeat (3) load(mk(1, 0, 2'd2, 2'd0, 0, 4'd2));
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t1_pc", pc, i % 3);
      tick();
      chk("t1_rd_req", rd_req, 1);
      chk("t1_wr_req", wr_req, 0);
      chk("t1_rd_bank", rd_bank, 2);
      chk("t1_rd_addr", rd_addr, 10'h010 + 2*i);
    end
    run = 1'b0;
    tick();
    chk("t1_idle_req", rd_req, 0);
    chk("t1_final_addr", rd_addr, 10'h01C);

    // 2: write from PE2, wrapping address
    pe_data = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
    start(10'h000, 10'h3FF);
    load(mk(0, 1, 2'd1, 2'd2, 0, 4'd1));
    run = 1'b1;
    tick();
    chk("t2_wr_req0", wr_req, 1);
    chk("t2_rd_req0", rd_req, 0);
    chk("t2_wr_bank", wr_bank, 1);
    chk("t2_wr_data", wr_data, 32'hDEAD_BEEF);
    chk("t2_wr_addr0", wr_addr, 10'h3FF);
    tick();
    chk("t2_wr_req1", wr_req, 1);
    chk("t2_wr_addr1", wr_addr, 10'h000);
    run = 1'b0;
    tick();

    // 3: overflow the program; 33rd (write) word must never execute
    start(10'h000, 10'h000);
    for (int i = 0; i < 32; i++) load(mk(1, 0, 2'd0, 2'd0, 0, 4'd0));
    chk("t3_ovf_before", cfg_ovf, 0);
    load(mk(0, 1, 2'd3, 2'd0, 0, 4'd0));
    chk("t3_ovf_after", cfg_ovf, 1);
    run = 1'b1;
    for (int i = 0; i < 33; i++) begin
      chk("t3_pc", pc, i % 32);
      tick();
      chk("t3_rd_req", rd_req, 1);
      chk("t3_wr_req", wr_req, 0);
    end
    run = 1'b0;
    tick();
    chk("t3_ovf_sticky", cfg_ovf, 1);
    start(10'h000, 10'h000);
    chk("t3_ovf_clr", cfg_ovf, 0);

    // 4: load capture coincident with cfg_start, then store of loaded value
    pe_data   = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    rd_valid  = 1'b1;
    rd_data   = 32'h0000_1234;
    start(10'h000, 10'h020);
    rd_valid  = 1'b0;
    rd_data   = 32'h0000_5555;
    chk("t4_load", lsu_to_pe, 32'h0000_1234);
    load(mk(0, 1, 2'd0, 2'd3, 1, 4'd0));
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("t4_wr_req", wr_req, 1);
    chk("t4_wr_data", wr_data, 32'h0000_1234);
    chk("t4_load_hold", lsu_to_pe, 32'h0000_1234);
    tick();

    // 5: run ignored when empty or while configuring; pause and resume
    start(10'h100, 10'h000);
    run = 1'b1;
    repeat (2) begin
      tick();
      chk("t5_empty_req", rd_req, 0);
      chk("t5_empty_pc", pc, 0);
    end
    load(mk(1, 0, 2'd0, 2'd0, 0, 4'd1));
    chk("t5_cfgrun_req", rd_req, 0);
    load(mk(1, 0, 2'd3, 2'd0, 0, 4'd1));
    chk("t5_cfgrun_req2", rd_req, 0);
    chk("t5_cfgrun_pc", pc, 0);
    tick();
    chk("t5_run_req", rd_req, 1);
    chk("t5_run_bank", rd_bank, 0);
    chk("t5_run_pc", pc, 1);
    run = 1'b0;
    repeat (2) begin
      tick();
      chk("t5_pause_req", rd_req, 0);
      chk("t5_pause_pc", pc, 1);
    end
    chk("t5_pause_addr", rd_addr, 10'h101);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("t5_resume_req", rd_req, 1);
    chk("t5_resume_bank", rd_bank, 3);
    chk("t5_resume_addr", rd_addr, 10'h101);
    chk("t5_resume_pc", pc, 0);
    tick();

    // 6: perf counters, 5 reads / 3 writes
    start(10'h000, 10'h000);
    load(mk(1, 1, 2'd0, 2'd0, 0, 4'd1));
    load(mk(1, 0, 2'd0, 2'd0, 0, 4'd1));
    run = 1'b1;
    repeat (5) tick();
    run = 1'b0;
    tick();
`ifdef LSU_PERF_CNT_EN
    chk("t6_rd_cnt", rd_cnt, 5);
    chk("t6_wr_cnt", wr_cnt, 3);
`else
    chk("t6_rd_cnt", rd_cnt, 0);
    chk("t6_wr_cnt", wr_cnt, 0);
`endif
    start(10'h000, 10'h000);
    chk("t6_rd_cnt_clr", rd_cnt, 0);
    chk("t6_wr_cnt_clr", wr_cnt, 0);

    // 7: asynchronous reset aborts a write immediately
    start(10'h000, 10'h050);
    load(mk(0, 1, 2'd2, 2'd1, 0, 4'd1));
    run = 1'b1;
    tick();
    chk("t7_wr_req_pre", wr_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("t7_wr_req_abort", wr_req, 0);
    chk("t7_wr_addr_abort", wr_addr, 0);
    chk("t7_wr_data_abort", wr_data, 32'hFFFF_FFFF);
    rst = 1'b1;
    tick();
    chk("t7_post_wr_req", wr_req, 0);
    chk("t7_post_pc", pc, 0);
    run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
